// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encodings and default width for the alu_seq execution unit.
package alu_pkg;

   localparam int W_DEF = 8;

   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SHR  = 4'd8;
   localparam logic [3:0] OP_INC  = 4'd9;
   localparam logic [3:0] OP_DEC  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the AC/bus side and the alu_seq execution unit.
interface alu_seq_if
   import alu_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] Dout;
   logic [W-1:0] hi;
   logic         busy;
   logic         done;
   logic         zf;
   logic         cf;
   logic         nf;

   modport master (
      output start, op, a, b,
      input  Dout, hi, busy, done, zf, cf, nf
   );

   modport slave (
      input  start, op, a, b,
      output Dout, hi, busy, done, zf, cf, nf
   );
endinterface

// File: rtl/alu_iter.sv
// Shared iterative datapath: shift-add multiply or restoring unsigned divide, one bit per step.
module alu_iter
   import alu_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mode,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res,
   output logic [W-1:0] rem
);

   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic [W-1:0] b_q, b_d;
   logic         mode_q, mode_d;
   logic [W:0]   sum;
   logic [W:0]   shifted;
   logic [W:0]   diff;

   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      mode_d  = mode_q;
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shifted = {hi_q, lo_q[W-1]};
      diff    = shifted - {1'b0, b_q};
      if (load) begin
         hi_d   = '0;
         lo_d   = a;
         b_d    = b;
         mode_d = mode;
      end else if (step) begin
         if (mode_q == MODE_MUL) begin
            {hi_d, lo_d} = {sum, lo_q[W-1:1]};
         end else if (!diff[W]) begin
            hi_d = diff[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_d = shifted[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         mode_q <= MODE_MUL;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         b_q    <= b_d;
         mode_q <= mode_d;
      end
   end

   // Post-step values, so the top can capture the final iteration on the same edge.
   assign res = lo_d;
   assign rem = hi_d;

endmodule

// File: rtl/alu_seq.sv
// 8-bit execution unit feeding AC: single-cycle ALU ops plus multi-cycle MUL/DIV with start/busy/done.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);

   localparam int CW = $clog2(W);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  dout_q, dout_d;
   logic [W-1:0]  hi_q, hi_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          zf_q, zf_d;
   logic          cf_q, cf_d;
   logic          nf_q, nf_d;

   logic [W:0]    alu_r;
   logic          wr;
   logic          iter_load, iter_step, iter_mode;
   logic [W-1:0]  iter_res, iter_rem;

   alu_iter #(.W(W)) u_iter (
      .clk  (clk),
      .rst  (rst),
      .mode (iter_mode),
      .load (iter_load),
      .step (iter_step),
      .a    (bus.a),
      .b    (bus.b),
      .res  (iter_res),
      .rem  (iter_rem)
   );

   // alu_r = {carry/borrow, result}
   always_comb begin
      case (bus.op)
         OP_PASS: alu_r = {1'b0, bus.b};
         OP_ADD:  alu_r = {1'b0, bus.a} + {1'b0, bus.b};
         OP_SUB:  alu_r = {1'b0, bus.a} - {1'b0, bus.b};
         OP_AND:  alu_r = {1'b0, bus.a & bus.b};
         OP_OR:   alu_r = {1'b0, bus.a | bus.b};
         OP_XOR:  alu_r = {1'b0, bus.a ^ bus.b};
         OP_NOT:  alu_r = {1'b0, ~bus.a};
         OP_SHL:  alu_r = {bus.a[W-1], bus.a[W-2:0], 1'b0};
         OP_SHR:  alu_r = {bus.a[0], 1'b0, bus.a[W-1:1]};
         OP_INC:  alu_r = {1'b0, bus.a} + (W+1)'(1);
         OP_DEC:  alu_r = {1'b0, bus.a} - (W+1)'(1);
         default: alu_r = {1'b0, bus.b};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      hi_d      = hi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cf_d      = cf_q;
      wr        = 1'b0;
      iter_load = 1'b0;
      iter_step = 1'b0;
      iter_mode = MODE_MUL;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) begin
                  iter_load = 1'b1;
                  iter_mode = (bus.op == OP_DIV) ? MODE_DIV : MODE_MUL;
                  busy_d    = 1'b1;
                  cnt_d     = '0;
                  state_d   = (bus.op == OP_DIV) ? S_DIV : S_MUL;
               end else if (bus.op == OP_DIV) begin
                  dout_d = '1;
                  hi_d   = bus.a;
                  cf_d   = 1'b1;
                  wr     = 1'b1;
                  done_d = 1'b1;
               end else begin
                  dout_d = alu_r[W-1:0];
                  hi_d   = '0;
                  cf_d   = alu_r[W];
                  wr     = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         S_MUL, S_DIV: begin
            iter_step = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) begin
               dout_d  = iter_res;
               hi_d    = iter_rem;
               cf_d    = (state_q == S_MUL) ? (iter_rem != '0) : 1'b0;
               wr      = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
      // zf/nf track Dout only when it is rewritten; reset leaves both at 0.
      zf_d = wr ? (dout_d == '0) : zf_q;
      nf_d = wr ? dout_d[W-1]    : nf_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         hi_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         zf_q    <= 1'b0;
         cf_q    <= 1'b0;
         nf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         hi_q    <= hi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         zf_q    <= zf_d;
         cf_q    <= cf_d;
         nf_q    <= nf_d;
      end
   end

   assign bus.Dout = dout_q;
   assign bus.hi   = hi_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.zf   = zf_q;
   assign bus.cf   = cf_q;
   assign bus.nf   = nf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued on issue, compared on each done pulse.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_seq_if #(.W(W)) bus ();

   alu_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] h;
      logic       c;
      logic       z;
      logic       n;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t        e;
      logic [15:0] p;
      e = '0;
      case (op)
         4'd1:  begin e.d = a + b; e.c = ({1'b0, a} + {1'b0, b}) > 9'd255; end
         4'd2:  begin e.d = a - b; e.c = (a < b); end
         4'd3:  e.d = a & b;
         4'd4:  e.d = a | b;
         4'd5:  e.d = a ^ b;
         4'd6:  e.d = ~a;
         4'd7:  begin e.d = a << 1; e.c = a[7]; end
         4'd8:  begin e.d = a >> 1; e.c = a[0]; end
         4'd9:  begin e.d = a + 8'd1; e.c = (a == 8'hFF); end
         4'd10: begin e.d = a - 8'd1; e.c = (a == 8'h00); end
         4'd11: begin
            p   = 16'(a) * 16'(b);
            e.d = p[7:0];
            e.h = p[15:8];
            e.c = (p[15:8] != 8'h00);
         end
         4'd12: begin
            if (b == 8'h00) begin
               e.d = 8'hFF; e.h = a; e.c = 1'b1;
            end else begin
               e.d = a / b; e.h = a % b;
            end
         end
         default: e.d = b;
      endcase
      e.z = (e.d == 8'h00);
      e.n = e.d[7];
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst === 1'b1 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", bus.done, 1'b0);
         end else begin
            e = sb.pop_front();
            check("dout", bus.Dout, e.d);
            check("hi",   bus.hi,   e.h);
            check("cf",   bus.cf,   e.c);
            check("zf",   bus.zf,   e.z);
            check("nf",   bus.nf,   e.n);
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen, so the next call lands in the done cycle.
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit poke);
      int lat  = 0;
      int bcyc = 0;
      bit multi;
      multi     = (op == OP_MUL) || (op == OP_DIV && b != 8'h00);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      sb.push_back(model(op, a, b));
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         bus.start = 1'b0;
         if (poke && lat == 3) begin
            bus.start = 1'b1;
            bus.op    = OP_ADD;
            bus.a     = 8'h55;
            bus.b     = 8'hAA;
         end
         if (bus.busy === 1'b1) bcyc++;
         if (bus.done === 1'b1) break;
      end
      check($sformatf("latency_op%0d", op), lat, multi ? 9 : 1);
      check($sformatf("busy_cycles_op%0d", op), bcyc, multi ? 8 : 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dout"}, bus.Dout, 8'h00);
      check({tag, "_hi"},   bus.hi,   8'h00);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_done"}, bus.done, 1'b0);
      check({tag, "_zf"},   bus.zf,   1'b0);
      check({tag, "_cf"},   bus.cf,   1'b0);
      check({tag, "_nf"},   bus.nf,   1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("init_rst");
      rst = 1'b1;
      @(negedge clk);

      issue(OP_ADD, 8'hF0, 8'h20, 1'b0);
      issue(OP_SUB, 8'h05, 8'h06, 1'b0);
      issue(OP_MUL, 8'h0F, 8'h11, 1'b0);
      issue(OP_MUL, 8'h80, 8'h04, 1'b0);
      issue(OP_DIV, 8'd200, 8'd7, 1'b0);
      issue(OP_DIV, 8'h33, 8'h00, 1'b0);
      issue(OP_MUL, 8'h0D, 8'h0B, 1'b1);
      issue(OP_DIV, 8'hFF, 8'h10, 1'b1);
      repeat (3) @(negedge clk);

      issue(OP_INC, 8'hFF, 8'h00, 1'b0);
      issue(OP_DEC, 8'h00, 8'h00, 1'b0);
      issue(OP_SHL, 8'h80, 8'h00, 1'b0);
      issue(OP_SHR, 8'h01, 8'h00, 1'b0);
      issue(OP_ADD, 8'hFF, 8'h01, 1'b0);
      issue(OP_MUL, 8'hFF, 8'hFF, 1'b0);
      issue(OP_DIV, 8'hFF, 8'h01, 1'b0);
      issue(OP_DIV, 8'h00, 8'h05, 1'b0);
      issue(4'd14, 8'h12, 8'h34, 1'b0);

      for (int unsigned i = 0; i < 48; i++) begin
         issue(4'(i % 16), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
         if (i % 7 == 3) repeat (2) @(negedge clk);
      end

      // Leave a non-zero result in Dout, then abandon a MUL at iteration 4.
      issue(OP_SUB, 8'h05, 8'h06, 1'b0);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.a     = 8'h0F;
      bus.b     = 8'h11;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_before_rst", bus.busy, 1'b1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_rst");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("done_after_abandon", bus.done, 1'b0);
      issue(OP_DIV, 8'd9, 8'd3, 1'b0);
      repeat (3) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- 8-bit execution unit directly upstream of the AC accumulator register; its registered result drives the AC data input.
- Its one-cycle `done` pulse drives AC's load strobe; operand A comes from the AC output, operand B from the data bus.
- Single-cycle logic/arithmetic ops, plus multi-cycle shift-add MUL and restoring DIV under a start/busy/done handshake.

Parameters:
- W, 8: datapath width; MUL and DIV iteration count equals W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset, 1 = normal operation.
- start  input  1  operation request; sampled only in IDLE.
- op  input  4  opcode, captured with start.
- a  input  W  operand A (AC value).
- b  input  W  operand B (memory/bus value).
- Dout  output  W  registered result to AC.
- hi  output  W  MUL high byte / DIV remainder; 0 for all other ops.
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle result-valid pulse; connects to AC load.
- zf  output  1  zero flag: Dout==0.
- cf  output  1  carry/borrow/overflow flag.
- nf  output  1  negative flag: Dout[W-1].

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE; Dout, hi, busy, done, zf, cf, nf all 0; iteration counter 0. An in-flight MUL/DIV is abandoned and produces no done.
- Opcodes:
  - 0 PASS: B.
  - 1 ADD: cf = carry out.
  - 2 SUB (A-B): cf = borrow.
  - 3 AND, 4 OR, 5 XOR.
  - 6 NOT A.
  - 7 SHL A: cf = A[7].
  - 8 SHR A (logical): cf = A[0].
  - 9 INC A: cf = carry.
  - 10 DEC A: cf = borrow.
  - 11 MUL, 12 DIV.
  - 13-15: treated as PASS B.
- Unless stated per op, cf=0 and hi=0.
- States: IDLE, MUL, DIV.
- IDLE, start=1 sampled at edge k:
  - Single-cycle op: Dout/flags/hi written at edge k; done=1 for the cycle after edge k; remain in IDLE.
  - MUL/DIV: operands latched, busy=1, counter=0, go to MUL/DIV; done stays 0.
- MUL: shift-add, one bit per edge.
  - At the edge where counter reaches W-1 (edge k+W): Dout = product[7:0], hi = product[15:8], cf = (hi!=0); busy=0, done=1 for one cycle; return to IDLE.
  - Total latency: W+1 edges from the start-sample edge to done visible.
- DIV: restoring, unsigned, same timing as MUL; Dout = quotient, hi = remainder, cf=0.
- DIV with b==0: no iteration; at edge k, Dout=0xFF, hi=A, cf=1; done next cycle; stays IDLE.
- Flags zf/nf always derive from the new Dout value and update only with Dout.
- Flags and Dout hold their value between operations; done is 0 except for the single pulse.
- start while busy=1 is ignored; no queueing. op/a/b changes during MUL/DIV have no effect (operands latched).
- start=1 in the done cycle is legal: a new op is accepted back-to-back.
- op not a single-cycle op and not MUL/DIV cannot occur (13-15 map to PASS).

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_PASS..OP_DIV);
  - state encoding (S_IDLE, S_MUL, S_DIV);
  - W default.
- One natural sub-module: alu_iter. It is the shared shift/accumulate datapath for MUL and DIV (mode select, load, step) and exposes a result/remainder pair.
- The top holds the FSM, counter, combinational single-cycle ops and output registers.

Test Plan:
- Reset check: rst=0 mid-stream -> all outputs 0 immediately (async); release -> IDLE.
- ADD a=0xF0, b=0x20 -> one cycle later Dout=0x10, cf=1, zf=0, nf=0, done single pulse. SUB a=0x05, b=0x06 -> Dout=0xFF, cf=1, nf=1.
- MUL a=0x0F, b=0x11 -> after 9 edges Dout=0xFF, hi=0x00, cf=0. MUL a=0x80, b=0x04 -> Dout=0x00, hi=0x02, cf=1, zf=1. busy high exactly 8 cycles.
- DIV a=200, b=7 -> Dout=0x1C, hi=0x04 after 9 edges. DIV a=0x33, b=0 -> next cycle Dout=0xFF, hi=0x33, cf=1, busy never set.
- start pulsed with op=ADD during MUL busy -> ignored; MUL result unaffected. Back-to-back start in the done cycle -> second op accepted.
- rst asserted at MUL iteration 4 -> no done; after release, DIV a=9, b=3 -> Dout=3, hi=0 correct.
